// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit
//   Owns the register file write port (WE3/A3/WD3) and merges two result sources into it:
//   ALU results (one per cycle, buffered in a small FIFO when the port is busy) and load data
//   returning from data memory with variable latency (one load outstanding, size/sign-extended).
//   Write priority per cycle: load response, FIFO head, bypassed ALU result.
//
// Ports
//   clk, areset                 clock (rising edge), asynchronous active-low reset
//   alu_valid/alu_rd/alu_data   ALU result in; alu_ready out (accepted when both high)
//   ld_req_valid/ld_rd/ld_funct3 load issue in; ld_req_ready out
//   mem_rvalid/mem_rdata        load data returning (right-aligned)
//   ld_pending/ld_pending_rd    outstanding load status
//   WE3/A3/WD3                  registered register-file write port
//   rd_pending_mask             (only with WB_PENDING_MASK_EN) per-register pending-write mask
//
// Optional feature macro: WB_PENDING_MASK_EN
module reg_writeback_unit #(
  parameter int unsigned width         = 32,
  parameter int unsigned address_lines = 5,
  parameter int unsigned depth         = 4
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     alu_valid,
  input  logic [address_lines-1:0] alu_rd,
  input  logic [width-1:0]         alu_data,
  output logic                     alu_ready,
  input  logic                     ld_req_valid,
  input  logic [address_lines-1:0] ld_rd,
  input  logic [2:0]               ld_funct3,
  output logic                     ld_req_ready,
  input  logic                     mem_rvalid,
  input  logic [width-1:0]         mem_rdata,
  output logic                     ld_pending,
  output logic [address_lines-1:0] ld_pending_rd,
  output logic                     WE3,
  output logic [address_lines-1:0] A3,
  output logic [width-1:0]         WD3
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [2**address_lines-1:0] rd_pending_mask
`endif
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StIdle, StWaitLoad} state_e;

  state_e                   r_state;
  logic [address_lines-1:0] r_ld_rd;
  logic [2:0]               r_ld_funct3;
  logic [PtrW-1:0]          r_wr_ptr;
  logic [PtrW-1:0]          r_rd_ptr;
  logic [CntW-1:0]          r_count;
  logic [address_lines-1:0] r_fifo_rd   [depth];
  logic [width-1:0]         r_fifo_data [depth];

  logic             w_full;
  logic             w_empty;
  logic             w_waw_block;
  logic             w_alu_live;
  logic             w_ld_resp;
  logic             w_pop;
  logic             w_bypass;
  logic             w_push;
  logic [width-1:0] w_ld_ext;

  assign ld_req_ready  = (r_state == StIdle);
  assign ld_pending    = (r_state == StWaitLoad);
  assign ld_pending_rd = ld_pending ? r_ld_rd : '0;

  // Full uses registered occupancy only, so a same-cycle pop never reopens a full FIFO.
  assign w_full  = (r_count == CntW'(depth));
  assign w_empty = (r_count == '0);

  // An ALU write to the rd of the outstanding load must not overtake the load's write.
  assign w_waw_block = ld_pending && (alu_rd == r_ld_rd) && (alu_rd != '0);
  assign alu_ready   = !w_full && !w_waw_block;

  // Results to x0 are accepted but never reach the write port or the FIFO.
  assign w_alu_live = alu_valid && alu_ready && (alu_rd != '0);
  assign w_ld_resp  = ld_pending && mem_rvalid;
  assign w_pop      = !w_ld_resp && !w_empty;
  assign w_bypass   = !w_ld_resp && w_empty && w_alu_live;
  assign w_push     = w_alu_live && !w_bypass;

  always_comb begin
    w_ld_ext = mem_rdata;
    case (r_ld_funct3)
      3'b000:  w_ld_ext = {{(width-8){mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  w_ld_ext = {{(width-16){mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  w_ld_ext = {{(width-8){1'b0}}, mem_rdata[7:0]};
      3'b101:  w_ld_ext = {{(width-16){1'b0}}, mem_rdata[15:0]};
      default: w_ld_ext = mem_rdata;
    endcase
  end

  // FIFO storage needs no reset: occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= alu_rd;
      r_fifo_data[r_wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state     <= StIdle;
      r_ld_rd     <= '0;
      r_ld_funct3 <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      WE3         <= 1'b0;
      A3          <= '0;
      WD3         <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (ld_req_valid) begin
            r_state     <= StWaitLoad;
            r_ld_rd     <= ld_rd;
            r_ld_funct3 <= ld_funct3;
          end
        end
        StWaitLoad: begin
          if (mem_rvalid) r_state <= StIdle;
        end
      endcase

      WE3 <= 1'b0;
      if (w_ld_resp) begin
        // A load to x0 still occupies the port this cycle but produces no write.
        WE3 <= (r_ld_rd != '0);
        A3  <= r_ld_rd;
        WD3 <= w_ld_ext;
      end else if (w_pop) begin
        WE3 <= 1'b1;
        A3  <= r_fifo_rd[r_rd_ptr];
        WD3 <= r_fifo_data[r_rd_ptr];
      end else if (w_bypass) begin
        WE3 <= 1'b1;
        A3  <= alu_rd;
        WD3 <= alu_data;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

`ifdef WB_PENDING_MASK_EN
  always_comb begin
    logic [PtrW-1:0] idx;
    rd_pending_mask = '0;
    idx             = '0;
    for (int unsigned i = 0; i < depth; i++) begin
      idx = r_rd_ptr + PtrW'(i);
      if (CntW'(i) < r_count) rd_pending_mask[r_fifo_rd[idx]] = 1'b1;
    end
    if (ld_pending) rd_pending_mask[r_ld_rd] = 1'b1;
    if (WE3)        rd_pending_mask[A3]      = 1'b1;
    rd_pending_mask[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Testbench for reg_writeback_unit: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the write-back rules.
module tb_reg_writeback_unit;

  localparam int W  = 32;
  localparam int AL = 5;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          areset;
  logic          alu_valid;
  logic [AL-1:0] alu_rd;
  logic [W-1:0]  alu_data;
  logic          alu_ready;
  logic          ld_req_valid;
  logic [AL-1:0] ld_rd;
  logic [2:0]    ld_funct3;
  logic          ld_req_ready;
  logic          mem_rvalid;
  logic [W-1:0]  mem_rdata;
  logic          ld_pending;
  logic [AL-1:0] ld_pending_rd;
  logic          WE3;
  logic [AL-1:0] A3;
  logic [W-1:0]  WD3;
`ifdef WB_PENDING_MASK_EN
  logic [2**AL-1:0] rd_pending_mask;
`endif

  reg_writeback_unit #(.width(W), .address_lines(AL), .depth(D)) dut (
    .clk          (clk),
    .areset       (areset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .ld_req_valid (ld_req_valid),
    .ld_rd        (ld_rd),
    .ld_funct3    (ld_funct3),
    .ld_req_ready (ld_req_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .ld_pending   (ld_pending),
    .ld_pending_rd(ld_pending_rd),
    .WE3          (WE3),
    .A3           (A3),
    .WD3          (WD3)
`ifdef WB_PENDING_MASK_EN
    ,
    .rd_pending_mask(rd_pending_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AL-1:0] rd;
    logic [W-1:0]  data;
  } wr_t;

  // Reference model state
  bit         m_pend;
  logic [4:0] m_pend_rd;
  logic [2:0] m_pend_f3;
  wr_t        m_q[$];
  logic [31:0] m_rf[32];
  logic [31:0] d_rf[32];
  wr_t        wlog[$];

  int n_checks;
  int n_pass;

  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = d & 32'hFF;
    h = d & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  task automatic idle_inputs();
    alu_valid    = 1'b0;
    alu_rd       = '0;
    alu_data     = '0;
    ld_req_valid = 1'b0;
    ld_rd        = '0;
    ld_funct3    = '0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
  endtask

  task automatic model_reset();
    m_pend    = 1'b0;
    m_pend_rd = '0;
    m_pend_f3 = '0;
    m_q.delete();
  endtask

  // One clock cycle with the currently driven inputs: compares handshake outputs before the
  // edge and the write port after it against the model.
  task automatic step();
    logic        exp_ready;
    logic        exp_we;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    bit          resp;
    bit          live;
    bit          used;
    wr_t         w;
    #1;
    exp_ready = (m_q.size() < D) && !(m_pend && alu_rd == m_pend_rd && alu_rd != 0);
    n_checks++;
    if (alu_ready !== exp_ready)
      $display("FAIL alu_ready t=%0t: got %b expected %b", $time, alu_ready, exp_ready);
    else n_pass++;
    n_checks++;
    if (ld_req_ready !== !m_pend)
      $display("FAIL ld_req_ready t=%0t: got %b expected %b", $time, ld_req_ready, !m_pend);
    else n_pass++;
    n_checks++;
    if (ld_pending !== m_pend)
      $display("FAIL ld_pending t=%0t: got %b expected %b", $time, ld_pending, m_pend);
    else n_pass++;
    n_checks++;
    if (ld_pending_rd !== (m_pend ? m_pend_rd : 5'd0))
      $display("FAIL ld_pending_rd t=%0t: got %0d expected %0d", $time, ld_pending_rd,
               m_pend ? m_pend_rd : 5'd0);
    else n_pass++;

    resp   = m_pend && mem_rvalid;
    live   = alu_valid && exp_ready && alu_rd != 0;
    used   = 1'b0;
    exp_we = 1'b0;
    exp_a  = '0;
    exp_d  = '0;
    if (resp) begin
      exp_we = (m_pend_rd != 0);
      exp_a  = m_pend_rd;
      exp_d  = ext_load(m_pend_f3, mem_rdata);
    end else if (m_q.size() != 0) begin
      w      = m_q.pop_front();
      exp_we = 1'b1;
      exp_a  = w.rd;
      exp_d  = w.data;
    end else if (live) begin
      exp_we = 1'b1;
      exp_a  = alu_rd;
      exp_d  = alu_data;
      used   = 1'b1;
    end
    if (live && !used) begin
      w.rd   = alu_rd;
      w.data = alu_data;
      m_q.push_back(w);
    end
    if (m_pend) begin
      if (mem_rvalid) m_pend = 1'b0;
    end else if (ld_req_valid) begin
      m_pend    = 1'b1;
      m_pend_rd = ld_rd;
      m_pend_f3 = ld_funct3;
    end
    if (exp_we) m_rf[exp_a] = exp_d;

    @(posedge clk);
    #1;
    n_checks++;
    if (WE3 !== exp_we)
      $display("FAIL WE3 t=%0t: got %b expected %b", $time, WE3, exp_we);
    else n_pass++;
    if (exp_we) begin
      n_checks++;
      if (A3 !== exp_a || WD3 !== exp_d)
        $display("FAIL write t=%0t: got A3=%0d WD3=%h expected A3=%0d WD3=%h", $time, A3, WD3,
                 exp_a, exp_d);
      else n_pass++;
    end
    if (WE3 === 1'b1) begin
      d_rf[A3] = WD3;
      w.rd     = A3;
      w.data   = WD3;
      wlog.push_back(w);
    end
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 20 && (m_q.size() != 0 || m_pend); i++) begin
      mem_rvalid = m_pend;
      mem_rdata  = $urandom;
      step();
    end
    idle_inputs();
    n_checks++;
    if (m_q.size() != 0 || m_pend)
      $display("FAIL drain: got %0d queued pend=%b expected empty", m_q.size(), m_pend);
    else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    areset = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0)
      $display("FAIL reset_port: got WE3=%b A3=%0d WD3=%h expected 0/0/0", WE3, A3, WD3);
    else n_pass++;
    n_checks++;
    if (ld_pending !== 1'b0 || ld_pending_rd !== 5'd0 || ld_req_ready !== 1'b1)
      $display("FAIL reset_load: got pend=%b rd=%0d rdy=%b expected 0/0/1", ld_pending,
               ld_pending_rd, ld_req_ready);
    else n_pass++;
    n_checks++;
    if (alu_ready !== 1'b1) $display("FAIL reset_alu_ready: got %b expected 1", alu_ready);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 areset = 1'b1;
  endtask

  task automatic test_alu_single();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h1234;
    step();
    idle_inputs();
    n_checks++;
    if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h1234)
      $display("FAIL alu_single: got WE3=%b A3=%0d WD3=%h expected 1/5/00001234", WE3, A3, WD3);
    else n_pass++;
    step();
    n_checks++;
    if (WE3 !== 1'b0) $display("FAIL alu_single_pulse: got WE3=%b expected 0", WE3);
    else n_pass++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd3};
    logic [31:0] rds [6] = '{32'hF0, 32'hF0, 32'h8001, 32'h8001, 32'hDEADBEEF, 32'h12345680};
    logic [31:0] exps[6] = '{32'hFFFFFFF0, 32'hF0, 32'hFFFF8001, 32'h8001, 32'hDEADBEEF,
                             32'h12345680};
    for (int i = 0; i < 6; i++) begin
      ld_req_valid = 1'b1;
      ld_rd        = 5'd7;
      ld_funct3    = f3s[i];
      step();
      idle_inputs();
      repeat (3) step();
      mem_rvalid = 1'b1;
      mem_rdata  = rds[i];
      step();
      idle_inputs();
      n_checks++;
      if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== exps[i] || ld_pending !== 1'b0)
        $display("FAIL load_ext[%0d]: got WE3=%b A3=%0d WD3=%h pend=%b expected 1/7/%h/0", i,
                 WE3, A3, WD3, ld_pending, exps[i]);
      else n_pass++;
    end
  endtask

  task automatic test_order();
    int start;
    logic [4:0] exp_rd [4] = '{5'd1, 5'd3, 5'd2, 5'd4};
    start        = wlog.size();
    ld_req_valid = 1'b1;
    ld_rd        = 5'd3;
    ld_funct3    = 3'd2;
    step();
    idle_inputs();
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    alu_data  = $urandom;
    step();
    alu_rd     = 5'd2;
    alu_data   = $urandom;
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    step();
    mem_rvalid = 1'b0;
    alu_rd     = 5'd4;
    alu_data   = $urandom;
    step();
    idle_inputs();
    repeat (3) step();
    n_checks++;
    if (wlog.size() - start != 4)
      $display("FAIL order_count: got %0d writes expected 4", wlog.size() - start);
    else n_pass++;
    for (int i = 0; i < 4 && start + i < wlog.size(); i++) begin
      n_checks++;
      if (wlog[start+i].rd !== exp_rd[i])
        $display("FAIL order[%0d]: got rd=%0d expected rd=%0d", i, wlog[start+i].rd, exp_rd[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stream_fill();
    int start;
    int lows;
    start = wlog.size();
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(1 + i);
      alu_data  = $urandom;
      step();
    end
    idle_inputs();
    n_checks++;
    if (wlog.size() - start != 6)
      $display("FAIL stream_writes: got %0d writes expected 6", wlog.size() - start);
    else n_pass++;

    // Back-to-back load responses starve the FIFO of pops while ALU results keep arriving.
    lows = 0;
    for (int i = 0; i < 40 && lows < 3; i++) begin
      ld_req_valid = 1'b1;
      ld_rd        = 5'd20;
      ld_funct3    = 3'd2;
      mem_rvalid   = 1'b1;
      mem_rdata    = $urandom;
      alu_valid    = 1'b1;
      alu_rd       = 5'($urandom_range(1, 15));
      alu_data     = $urandom;
      #1;
      if (alu_ready === 1'b0) begin
        lows++;
        n_checks++;
        if (m_q.size() != D)
          $display("FAIL fill_low_occupancy: got ready=0 at occupancy %0d expected %0d",
                   m_q.size(), D);
        else n_pass++;
      end
      step();
    end
    n_checks++;
    if (lows == 0) $display("FAIL fill_reached: got 0 not-ready cycles expected >0");
    else n_pass++;
    drain();
  endtask

  task automatic test_waw();
    logic exp_rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ld_req_valid = 1'b1;
    ld_rd        = 5'd9;
    ld_funct3    = 3'd2;
    step();
    idle_inputs();
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 32'hA5A50009;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = (i == 3);
      mem_rdata  = 32'h1111;
      #1;
      n_checks++;
      if (alu_ready !== exp_rdy[i])
        $display("FAIL waw_ready[%0d]: got %b expected %b", i, alu_ready, exp_rdy[i]);
      else n_pass++;
      if (i == 4) alu_valid = alu_valid;
      step();
      if (i == 4) idle_inputs();
    end
    idle_inputs();
    step();
    n_checks++;
    if (d_rf[9] !== 32'hA5A50009)
      $display("FAIL waw_final: got x9=%h expected A5A50009", d_rf[9]);
    else n_pass++;
  endtask

  task automatic test_x0();
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = $urandom;
    step();
    idle_inputs();
    n_checks++;
    if (WE3 !== 1'b0) $display("FAIL x0_alu: got WE3=%b expected 0", WE3);
    else n_pass++;
    ld_req_valid = 1'b1;
    ld_rd        = 5'd0;
    ld_funct3    = 3'd2;
    step();
    idle_inputs();
    n_checks++;
    if (ld_pending !== 1'b1) $display("FAIL x0_load_pending: got %b expected 1", ld_pending);
    else n_pass++;
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    step();
    idle_inputs();
    n_checks++;
    if (WE3 !== 1'b0 || ld_pending !== 1'b0)
      $display("FAIL x0_load: got WE3=%b pend=%b expected 0/0", WE3, ld_pending);
    else n_pass++;
  endtask

  task automatic test_reset_wait();
    ld_req_valid = 1'b1;
    ld_rd        = 5'd12;
    ld_funct3    = 3'd0;
    step();
    idle_inputs();
    step();
    #2 areset = 1'b0;
    #1;
    n_checks++;
    if (ld_pending !== 1'b0 || ld_pending_rd !== 5'd0 || WE3 !== 1'b0)
      $display("FAIL reset_wait_async: got pend=%b rd=%0d WE3=%b expected 0/0/0", ld_pending,
               ld_pending_rd, WE3);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1 areset = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE0080;
    step();
    idle_inputs();
    n_checks++;
    if (WE3 !== 1'b0 || ld_pending !== 1'b0)
      $display("FAIL reset_wait_rvalid: got WE3=%b pend=%b expected 0/0", WE3, ld_pending);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_valid    = $urandom_range(0, 1) == 1;
      alu_rd       = 5'($urandom_range(0, 7));
      alu_data     = $urandom;
      ld_req_valid = $urandom_range(0, 3) == 0;
      ld_rd        = 5'($urandom_range(0, 7));
      ld_funct3    = 3'($urandom_range(0, 7));
      mem_rvalid   = $urandom_range(0, 2) == 0;
      mem_rdata    = $urandom;
      step();
    end
    drain();
    for (int r = 0; r < 32; r++) begin
      n_checks++;
      if (d_rf[r] !== m_rf[r])
        $display("FAIL rf[%0d]: got %h expected %h", r, d_rf[r], m_rf[r]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = '0;
      d_rf[r] = '0;
    end
    test_reset();
    test_alu_single();
    test_load_ext();
    test_order();
    test_stream_fill();
    test_waw();
    test_x0();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
